// File: rtl/mandelbrot_pixel_seq.sv
// Per-pixel sequencer for the Mandelbrot core: nibble-serial constant load, start strobe, escape counting.
// Optional cumulative ITER-cycle counter enabled by defining MANDEL_SEQ_PERF_EN.
module mandelbrot_pixel_seq #(
   parameter int ITER_W   = 8,
   parameter int MAX_ITER = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [31:0]       req_cr,
   input  logic [31:0]       req_ci,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [ITER_W-1:0] res_iter,
   output logic              res_escaped,
   output logic              acc_start,
   output logic [3:0]        acc_cr_nib,
   output logic [3:0]        acc_ci_nib,
   input  logic              acc_unbounded,
   output logic              busy,
   output logic [31:0]       perf_cycles
);

   localparam logic [ITER_W-1:0] MAX_ITER_C = ITER_W'(MAX_ITER);
   localparam logic [ITER_W-1:0] ONE_C      = ITER_W'(1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_START = 3'd2,
      S_SKIP  = 3'd3,
      S_ITER  = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t            state_r, state_s;
   logic [2:0]        k_r, k_s;
   logic [31:0]       cr_sh_r, cr_sh_s;
   logic [31:0]       ci_sh_r, ci_sh_s;
   logic [ITER_W-1:0] n_r, n_s;
   logic [ITER_W-1:0] res_iter_r, res_iter_s;
   logic              res_esc_r, res_esc_s;
   logic              req_ready_r, req_ready_s;
   logic              res_valid_r, res_valid_s;
   logic              busy_r, busy_s;
   logic              start_r, start_s;
   logic [3:0]        cr_nib_r, cr_nib_s;
   logic [3:0]        ci_nib_r, ci_nib_s;

   // Next-state and next-output logic; every output is computed for the state about to be entered.
   always_comb begin
      state_s    = state_r;
      k_s        = k_r;
      cr_sh_s    = cr_sh_r;
      ci_sh_s    = ci_sh_r;
      n_s        = n_r;
      res_iter_s = res_iter_r;
      res_esc_s  = res_esc_r;
      start_s    = 1'b0;
      cr_nib_s   = 4'h0;
      ci_nib_s   = 4'h0;
      case (state_r)
         S_IDLE: begin
            if (req_valid && req_ready_r) begin
               state_s  = S_LOAD;
               k_s      = 3'd0;
               cr_nib_s = req_cr[3:0];
               ci_nib_s = req_ci[3:0];
               cr_sh_s  = {4'h0, req_cr[31:4]};
               ci_sh_s  = {4'h0, req_ci[31:4]};
            end else begin
               state_s = S_IDLE;
            end
         end
         S_LOAD: begin
            // START must follow the eighth nibble directly, otherwise the core shifts once too often.
            if (k_r == 3'd7) begin
               state_s = S_START;
               start_s = 1'b1;
            end else begin
               k_s      = k_r + 3'd1;
               cr_nib_s = cr_sh_r[3:0];
               ci_nib_s = ci_sh_r[3:0];
               cr_sh_s  = {4'h0, cr_sh_r[31:4]};
               ci_sh_s  = {4'h0, ci_sh_r[31:4]};
            end
         end
         S_START: begin
            state_s = S_SKIP;
         end
         S_SKIP: begin
            // acc_unbounded still reflects the previous pixel here.
            n_s     = {ITER_W{1'b0}};
            state_s = S_ITER;
         end
         S_ITER: begin
            if (acc_unbounded) begin
               res_iter_s = n_r;
               res_esc_s  = 1'b1;
               state_s    = S_DONE;
            end else if ((n_r + ONE_C) == MAX_ITER_C) begin
               res_iter_s = MAX_ITER_C;
               res_esc_s  = 1'b0;
               state_s    = S_DONE;
            end else begin
               n_s = n_r + ONE_C;
            end
         end
         S_DONE: begin
            if (res_valid_r && res_ready) begin
               state_s = S_IDLE;
            end else begin
               state_s = S_DONE;
            end
         end
         default: begin
            state_s = S_IDLE;
         end
      endcase
      req_ready_s = (state_s == S_IDLE);
      res_valid_s = (state_s == S_DONE);
      busy_s      = (state_s != S_IDLE);
   end

   // State, datapath and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= S_IDLE;
         k_r         <= 3'd0;
         cr_sh_r     <= 32'd0;
         ci_sh_r     <= 32'd0;
         n_r         <= {ITER_W{1'b0}};
         res_iter_r  <= {ITER_W{1'b0}};
         res_esc_r   <= 1'b0;
         req_ready_r <= 1'b1;
         res_valid_r <= 1'b0;
         busy_r      <= 1'b0;
         start_r     <= 1'b0;
         cr_nib_r    <= 4'h0;
         ci_nib_r    <= 4'h0;
      end else begin
         state_r     <= state_s;
         k_r         <= k_s;
         cr_sh_r     <= cr_sh_s;
         ci_sh_r     <= ci_sh_s;
         n_r         <= n_s;
         res_iter_r  <= res_iter_s;
         res_esc_r   <= res_esc_s;
         req_ready_r <= req_ready_s;
         res_valid_r <= res_valid_s;
         busy_r      <= busy_s;
         start_r     <= start_s;
         cr_nib_r    <= cr_nib_s;
         ci_nib_r    <= ci_nib_s;
      end
   end

`ifdef MANDEL_SEQ_PERF_EN
   logic [31:0] perf_r;

   // Free-running count of ITER cycles, wraps naturally, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_r <= 32'd0;
      end else if (state_r == S_ITER) begin
         perf_r <= perf_r + 32'd1;
      end else begin
         perf_r <= perf_r;
      end
   end

   assign perf_cycles = perf_r;
`else
   assign perf_cycles = 32'd0;
`endif

   assign req_ready   = req_ready_r;
   assign res_valid   = res_valid_r;
   assign res_iter    = res_iter_r;
   assign res_escaped = res_esc_r;
   assign acc_start   = start_r;
   assign acc_cr_nib  = cr_nib_r;
   assign acc_ci_nib  = ci_nib_r;
   assign busy        = busy_r;

endmodule

// File: tb/tb_mandelbrot_pixel_seq.sv
// Scoreboard bench for mandelbrot_pixel_seq with a behavioural core model deciding each pixel's escape point.
module tb_mandelbrot_pixel_seq;
   localparam int ITER_W   = 8;
   localparam int MAX_ITER = 255;
`ifdef MANDEL_SEQ_PERF_EN
   localparam bit PERF_EN = 1'b1;
`else
   localparam bit PERF_EN = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic [31:0]       req_cr = 32'd0;
   logic [31:0]       req_ci = 32'd0;
   logic              res_valid;
   logic              res_ready = 1'b0;
   logic [ITER_W-1:0] res_iter;
   logic              res_escaped;
   logic              acc_start;
   logic [3:0]        acc_cr_nib;
   logic [3:0]        acc_ci_nib;
   logic              acc_unbounded;
   logic              busy;
   logic [31:0]       perf_cycles;

   mandelbrot_pixel_seq #(.ITER_W(ITER_W), .MAX_ITER(MAX_ITER)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_cr(req_cr), .req_ci(req_ci),
      .res_valid(res_valid), .res_ready(res_ready), .res_iter(res_iter), .res_escaped(res_escaped),
      .acc_start(acc_start), .acc_cr_nib(acc_cr_nib), .acc_ci_nib(acc_ci_nib),
      .acc_unbounded(acc_unbounded), .busy(busy), .perf_cycles(perf_cycles)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] cr;
      logic [31:0] ci;
      int          acc;
   } exp_t;

   exp_t        expq[$];
   logic [63:0] expc[$];
   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   int          hs_cyc = -100;
   int          rdy_mode = 0;
   longint      perf_exp = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Number of bounded iterations the core reports before flagging unbounded for constant C.
   function automatic int esc_of(input logic [31:0] cr, input logic [31:0] ci);
      if (cr == 32'd0 && ci == 32'd0) return 100000;
      if (cr[31:28] == 4'h7) return 0;
      return int'((cr[15:0] ^ ci[15:0])) % 300;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Core model: shifts nibbles in on non-start cycles, latches C on start, raises unbounded after esc_of iterations.
   logic [31:0] core_cr_r, core_ci_r, cap_cr_r, cap_ci_r;
   logic        cap_valid_r, core_run_r;
   int          core_c_r, core_e_r;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         core_cr_r <= 32'd0; core_ci_r <= 32'd0;
         cap_cr_r <= 32'd0; cap_ci_r <= 32'd0; cap_valid_r <= 1'b0;
         core_run_r <= 1'b0; core_c_r <= 0; core_e_r <= 0;
         acc_unbounded <= 1'b0;
      end else begin
         cap_valid_r <= 1'b0;
         if (acc_start) begin
            cap_cr_r <= core_cr_r; cap_ci_r <= core_ci_r; cap_valid_r <= 1'b1;
            core_e_r <= esc_of(core_cr_r, core_ci_r);
            core_c_r <= 0; core_run_r <= 1'b1;
         end else begin
            core_cr_r <= {acc_cr_nib, core_cr_r[31:4]};
            core_ci_r <= {acc_ci_nib, core_ci_r[31:4]};
            if (core_run_r) begin
               acc_unbounded <= (core_c_r >= core_e_r);
               core_c_r <= core_c_r + 1;
            end
         end
      end
   end

   // Monitor: drives res_ready, checks core capture, result latency, hold stability and result contents.
   initial begin
      bit          prev_valid;
      int          hold_cnt;
      logic [ITER_W-1:0] held_iter;
      logic        held_esc;
      prev_valid = 1'b0; hold_cnt = 0; held_iter = '0; held_esc = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_valid = 1'b0; hold_cnt = 0;
         end else begin
            if (res_valid) hold_cnt++; else hold_cnt = 0;
            case (rdy_mode)
               1: res_ready = ($urandom_range(0, 3) != 0);
               2: res_ready = (hold_cnt > 20);
               default: res_ready = 1'b1;
            endcase
            if (cap_valid_r) begin
               if (expc.size() == 0) check("core_capture_unexpected", 64'd1, 64'd0);
               else begin
                  logic [63:0] c;
                  c = expc.pop_front();
                  check("core_cr", cap_cr_r, c[63:32]);
                  check("core_ci", cap_ci_r, c[31:0]);
               end
            end
            if (res_valid) begin
               check("req_ready_in_done", req_ready, 1'b0);
               check("busy_in_done", busy, 1'b1);
               if (expq.size() == 0) check("result_unexpected", 64'd1, 64'd0);
               else begin
                  int e;
                  e = esc_of(expq[0].cr, expq[0].ci);
                  if (!prev_valid)
                     check("latency", cyc - expq[0].acc, (e < MAX_ITER) ? 12 + e : 11 + MAX_ITER);
                  else begin
                     check("hold_iter", res_iter, held_iter);
                     check("hold_escaped", res_escaped, held_esc);
                  end
                  held_iter = res_iter; held_esc = res_escaped;
                  if (res_ready) begin
                     void'(expq.pop_front());
                     check("res_iter", res_iter, (e < MAX_ITER) ? e : MAX_ITER);
                     check("res_escaped", res_escaped, (e < MAX_ITER) ? 1 : 0);
                     perf_exp += (e < MAX_ITER) ? e + 1 : MAX_ITER;
                     check("perf_cycles", perf_cycles, PERF_EN ? (perf_exp & 64'hFFFF_FFFF) : 0);
                     hs_cyc = cyc;
                  end
               end
            end
            prev_valid = res_valid;
         end
      end
   end

   // Issue a request at a negedge; the expected response is queued when the handshake is seen.
   task automatic send(input logic [31:0] cr, input logic [31:0] ci, input bit chk_b2b);
      int   w;
      exp_t e;
      req_cr = cr; req_ci = ci; req_valid = 1'b1;
      w = 0;
      while (!req_ready && w < 3000) begin @(negedge clk); w++; end
      if (!req_ready) begin
         check("accept_timeout", 64'd0, 64'd1);
         req_valid = 1'b0;
         return;
      end
      e.cr = cr; e.ci = ci; e.acc = cyc;
      expq.push_back(e);
      expc.push_back({cr, ci});
      if (chk_b2b) check("b2b_accept_cycle", cyc, hs_cyc + 1);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic drain();
      int w;
      w = 0;
      while ((expq.size() != 0) && w < 5000) begin @(negedge clk); w++; end
      check("drain_timeout", expq.size(), 0);
   endtask

   task automatic check_reset_vals();
      check("rst_req_ready", req_ready, 1'b1);
      check("rst_res_valid", res_valid, 1'b0);
      check("rst_res_iter", res_iter, 0);
      check("rst_res_escaped", res_escaped, 1'b0);
      check("rst_acc_start", acc_start, 1'b0);
      check("rst_nibs", {acc_cr_nib, acc_ci_nib}, 8'h00);
      check("rst_busy", busy, 1'b0);
      check("rst_perf", perf_cycles, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      #12;
      check_reset_vals();
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);

      // Origin never escapes, far constant escapes immediately, nibble-order pattern.
      send(32'h0000_0000, 32'h0000_0000, 1'b0); drain();
      send(32'h7000_0000, 32'h0000_0000, 1'b0); drain();
      send(32'h8765_4321, 32'h0123_4567, 1'b0); drain();

      // Consumer stalls 20 cycles while the next request waits.
      rdy_mode = 2;
      send(32'h0000_0010, 32'h0000_0001, 1'b0);
      send(32'h0000_0005, 32'h0000_0000, 1'b1);
      drain();

      // Back-to-back with stale unbounded=1 from the previous pixel in SKIP.
      rdy_mode = 0;
      send(32'h7ABC_0000, 32'h0000_1234, 1'b0);
      send(32'h0000_0003, 32'h0000_0000, 1'b1);
      drain();

      // Reset during LOAD k=4 discards the pixel.
      send(32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      expq.delete(); expc.delete(); perf_exp = 0;
      #1;
      check_reset_vals();
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      send(32'h0000_0020, 32'h0000_0002, 1'b0); drain();

      // Randomised requests with a random consumer.
      rdy_mode = 1;
      for (int i = 0; i < 14; i++) begin
         logic [31:0] rc, ri;
         rc = $urandom; ri = $urandom;
         if (i % 5 == 0) rc[31:28] = 4'h7;
         send(rc, ri, 1'b0);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      drain();
      repeat (5) @(negedge clk);
      check("final_idle_ready", req_ready, 1'b1);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
